mem_arbiter: RTL and testbench

Arbitrates a single-port, word-organised unified memory between the core's instruction-fetch port and its data port. It sits between `core_top`'s fetch/LSU and the memory macro. It issues at most one memory access per cycle and generates byte enables from the data-port write type. It also returns read data with fixed one-cycle latency, tagged to the requester that issued the read.

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and memory-side bus of mem_arbiter.
// slave is the arbiter's view; master is the core and memory-macro side.
interface mem_arbiter_if #(
  parameter int MEM_AW = 14
);
  logic              i_if_req;
  logic [31:0]       i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [31:0]       o_if_rdata;

  logic              i_dm_req;
  logic [31:0]       i_dm_addr;
  logic [1:0]        i_dm_wr_type;
  logic [31:0]       i_dm_wdata;
  logic              o_dm_gnt;
  logic              o_dm_rvalid;
  logic [31:0]       o_dm_rdata;
  logic              o_dm_err;

  logic              o_mem_en;
  logic [MEM_AW-1:0] o_mem_addr;
  logic [3:0]        o_mem_we;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  logic [31:0]       o_perf_conflict;
  logic [31:0]       o_perf_forced;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_dm_req, i_dm_addr, i_dm_wr_type, i_dm_wdata,
    output o_dm_gnt, o_dm_rvalid, o_dm_rdata, o_dm_err,
    output o_mem_en, o_mem_addr, o_mem_we, o_mem_wdata,
    input  i_mem_rdata,
    output o_perf_conflict, o_perf_forced
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_dm_req, i_dm_addr, i_dm_wr_type, i_dm_wdata,
    input  o_dm_gnt, o_dm_rvalid, o_dm_rdata, o_dm_err,
    input  o_mem_en, o_mem_addr, o_mem_we, o_mem_wdata,
    output i_mem_rdata,
    input  o_perf_conflict, o_perf_forced
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for fetch and data ports with starvation guard.
// Optional perf counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter #(
  parameter int MEM_AW     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;
  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  logic [3:0]  r_starve_cnt;
  logic [1:0]  r_owner;
  logic        r_dm_err;

  logic        w_both;
  logic        w_forced;
  logic        w_if_gnt;
  logic        w_dm_gnt;
  logic [3:0]  w_dm_we;
  logic [31:0] w_dm_wdata;
  logic        w_misalign;
  logic [1:0]  w_owner_nxt;
  logic        w_unused;

  assign w_unused = ^{bus.i_if_addr[31:MEM_AW+2], bus.i_if_addr[1:0],
                      bus.i_dm_addr[31:MEM_AW+2]};

  always_comb begin
    w_both   = bus.i_if_req & bus.i_dm_req;
    w_forced = w_both && (r_starve_cnt >= LP_STARVE_MAX);
    w_dm_gnt = !rst && bus.i_dm_req && !w_forced;
    w_if_gnt = !rst && bus.i_if_req && (!bus.i_dm_req || w_forced);
  end

  // Lane steering; a misaligned write keeps its grant but writes no bytes.
  always_comb begin
    w_dm_we    = 4'b0000;
    w_dm_wdata = 32'h0;
    w_misalign = 1'b0;
    case (bus.i_dm_wr_type)
      2'b01: begin
        w_dm_we    = 4'b0001 << bus.i_dm_addr[1:0];
        w_dm_wdata = {4{bus.i_dm_wdata[7:0]}};
      end
      2'b10: begin
        w_dm_wdata = {2{bus.i_dm_wdata[15:0]}};
        if (bus.i_dm_addr[0]) w_misalign = 1'b1;
        else                  w_dm_we = 4'b0011 << {bus.i_dm_addr[1], 1'b0};
      end
      2'b11: begin
        w_dm_wdata = bus.i_dm_wdata;
        if (bus.i_dm_addr[1:0] != 2'b00) w_misalign = 1'b1;
        else                             w_dm_we = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.o_if_gnt    = w_if_gnt;
    bus.o_dm_gnt    = w_dm_gnt;
    bus.o_mem_en    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_we    = 4'b0000;
    bus.o_mem_wdata = 32'h0;
    w_owner_nxt     = OWN_NONE;
    if (w_if_gnt) begin
      bus.o_mem_en   = 1'b1;
      bus.o_mem_addr = bus.i_if_addr[MEM_AW+1:2];
      w_owner_nxt    = OWN_IF;
    end else if (w_dm_gnt) begin
      bus.o_mem_en    = 1'b1;
      bus.o_mem_addr  = bus.i_dm_addr[MEM_AW+1:2];
      bus.o_mem_we    = w_dm_we;
      bus.o_mem_wdata = w_dm_wdata;
      if (bus.i_dm_wr_type == 2'b00) w_owner_nxt = OWN_DM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
      r_owner      <= OWN_NONE;
      r_dm_err     <= 1'b0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_dm_err <= w_dm_gnt && w_misalign;
      if (!bus.i_if_req || w_if_gnt)
        r_starve_cnt <= 4'd0;
      else if (w_dm_gnt && (r_starve_cnt < LP_STARVE_MAX))
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Gating with rst drops a response whose read was granted just before reset.
  always_comb begin
    bus.o_if_rvalid = !rst && (r_owner == OWN_IF);
    bus.o_dm_rvalid = !rst && (r_owner == OWN_DM);
    bus.o_if_rdata  = bus.o_if_rvalid ? bus.i_mem_rdata : 32'h0;
    bus.o_dm_rdata  = bus.o_dm_rvalid ? bus.i_mem_rdata : 32'h0;
    bus.o_dm_err    = !rst && r_dm_err;
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_conflict;
  logic [31:0] r_perf_forced;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_conflict <= 32'h0;
      r_perf_forced   <= 32'h0;
    end else begin
      if (w_both)              r_perf_conflict <= r_perf_conflict + 32'd1;
      if (w_if_gnt && w_forced) r_perf_forced  <= r_perf_forced + 32'd1;
    end
  end

  assign bus.o_perf_conflict = r_perf_conflict;
  assign bus.o_perf_forced   = r_perf_forced;
`else
  assign bus.o_perf_conflict = 32'h0;
  assign bus.o_perf_forced   = 32'h0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter with a behavioural memory macro.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  typedef struct {
    logic        if_rv;
    logic        dm_rv;
    logic [31:0] data;
    logic        err;
  } resp_t;
  resp_t sb[$];

  mem_arbiter_if #(.MEM_AW(14)) bus ();

  mem_arbiter #(.MEM_AW(14), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEADBEEF;
      bus.i_mem_rdata <= 32'h0;
    end else if (bus.o_mem_en) begin
      bus.i_mem_rdata <= mem[bus.o_mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.o_mem_we[b]) mem[bus.o_mem_addr][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic [31:0] ifa, input logic dmr,
                       input logic [31:0] dma, input logic [1:0] wt, input logic [31:0] wd);
    @(negedge clk);
    bus.i_if_req     = ifr;
    bus.i_if_addr    = ifa;
    bus.i_dm_req     = dmr;
    bus.i_dm_addr    = dma;
    bus.i_dm_wr_type = wt;
    bus.i_dm_wdata   = wd;
    #1;
  endtask

  task automatic chk_mem(input string tag, input logic ifg, input logic dmg,
                         input logic [13:0] a, input logic [3:0] we, input logic [31:0] wd);
    chk({tag, "_if_gnt"}, bus.o_if_gnt, ifg);
    chk({tag, "_dm_gnt"}, bus.o_dm_gnt, dmg);
    chk({tag, "_mem_en"}, bus.o_mem_en, ifg | dmg);
    chk({tag, "_mem_addr"}, bus.o_mem_addr, a);
    chk({tag, "_mem_we"}, bus.o_mem_we, we);
    chk({tag, "_mem_wdata"}, bus.o_mem_wdata, wd);
  endtask

  task automatic push(input logic ifv, input logic dmv, input logic [31:0] d, input logic e);
    resp_t r;
    r.if_rv = ifv;
    r.dm_rv = dmv;
    r.data  = d;
    r.err   = e;
    sb.push_back(r);
  endtask

  task automatic tick();
    resp_t r;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      r = sb.pop_front();
      chk("if_rvalid", bus.o_if_rvalid, r.if_rv);
      chk("dm_rvalid", bus.o_dm_rvalid, r.dm_rv);
      chk("if_rdata", bus.o_if_rdata, r.if_rv ? r.data : 32'h0);
      chk("dm_rdata", bus.o_dm_rdata, r.dm_rv ? r.data : 32'h0);
      chk("dm_err", bus.o_dm_err, r.err);
    end
  endtask

  logic [31:0] base_conf;
  logic [31:0] base_forced;
  logic        exp_dm;
  logic        ifr;

  initial begin
    bus.i_if_req     = 1'b0;
    bus.i_if_addr    = 32'h0;
    bus.i_dm_req     = 1'b0;
    bus.i_dm_addr    = 32'h0;
    bus.i_dm_wr_type = 2'b00;
    bus.i_dm_wdata   = 32'h0;

    // reset: combinational outputs held low even with both requests up
    drive(1'b1, 32'h10, 1'b1, 32'h100, 2'b00, 32'h0);
    chk_mem("rst", 1'b0, 1'b0, 14'h0, 4'b0000, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_if_rvalid", bus.o_if_rvalid, 1'b0);
    chk("rst_dm_rvalid", bus.o_dm_rvalid, 1'b0);
    chk("rst_dm_err", bus.o_dm_err, 1'b0);
    chk("rst_perf_conflict", bus.o_perf_conflict, 32'h0);
    chk("rst_perf_forced", bus.o_perf_forced, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_if_req = 1'b0;
    bus.i_dm_req = 1'b0;

    // lone fetch read
    drive(1'b1, 32'h80000010, 1'b0, 32'h0, 2'b00, 32'h0);
    chk_mem("fetch", 1'b1, 1'b0, 14'h4, 4'b0000, 32'h0);
    push(1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    tick();

    // byte and half writes, then read back to see lane masking
    drive(1'b0, 32'h0, 1'b1, 32'h103, 2'b01, 32'h000000AB);
    chk_mem("wr_byte", 1'b0, 1'b1, 14'h40, 4'b1000, 32'hABABABAB);
    push(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h202, 2'b10, 32'h00001234);
    chk_mem("wr_half", 1'b0, 1'b1, 14'h80, 4'b1100, 32'h12341234);
    push(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h100, 2'b00, 32'h0);
    chk_mem("rd_byte", 1'b0, 1'b1, 14'h40, 4'b0000, 32'h0);
    push(1'b0, 1'b1, 32'hAB000000, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h200, 2'b00, 32'h0);
    push(1'b0, 1'b1, 32'h12340000, 1'b0);
    tick();

    // misaligned word write: granted, no enables, error pulse, memory unchanged
    drive(1'b0, 32'h0, 1'b1, 32'h206, 2'b11, 32'hFFFFFFFF);
    chk("mis_dm_gnt", bus.o_dm_gnt, 1'b1);
    chk("mis_mem_en", bus.o_mem_en, 1'b1);
    chk("mis_mem_we", bus.o_mem_we, 4'b0000);
    push(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h204, 2'b00, 32'h0);
    push(1'b0, 1'b1, 32'h0, 1'b0);
    tick();

    // starvation guard: DM x4 then forced IF, repeating
    base_conf   = bus.o_perf_conflict;
    base_forced = bus.o_perf_forced;
    for (int i = 0; i < 10; i++) begin
      exp_dm = ((i % 5) != 4);
      drive(1'b1, 32'h10, 1'b1, 32'h100, 2'b00, 32'h0);
      chk("starve_if_gnt", bus.o_if_gnt, !exp_dm);
      chk("starve_dm_gnt", bus.o_dm_gnt, exp_dm);
      push(!exp_dm, exp_dm, exp_dm ? 32'hAB000000 : 32'hDEADBEEF, 1'b0);
      tick();
    end
`ifdef MEM_ARB_PERF_EN
    chk("perf_conflict", bus.o_perf_conflict - base_conf, 32'd10);
    chk("perf_forced", bus.o_perf_forced - base_forced, 32'd2);
`else
    chk("perf_conflict_off", bus.o_perf_conflict, 32'h0);
    chk("perf_forced_off", bus.o_perf_forced, 32'h0);
`endif

    // a cycle with fetch idle clears the starvation count
    for (int i = 0; i < 9; i++) begin
      ifr    = (i != 3);
      exp_dm = (i != 8);
      drive(ifr, 32'h10, 1'b1, 32'h100, 2'b00, 32'h0);
      chk("drop_if_gnt", bus.o_if_gnt, !exp_dm);
      chk("drop_dm_gnt", bus.o_dm_gnt, exp_dm);
      push(!exp_dm, exp_dm, exp_dm ? 32'hAB000000 : 32'hDEADBEEF, 1'b0);
      tick();
    end

    // reset while a data read response is due
    drive(1'b0, 32'h0, 1'b1, 32'h100, 2'b00, 32'h0);
    chk("rstmid_dm_gnt", bus.o_dm_gnt, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.i_dm_req = 1'b0;
    #1;
    chk("rstmid_t1_dm_rvalid", bus.o_dm_rvalid, 1'b0);
    chk("rstmid_t1_dm_rdata", bus.o_dm_rdata, 32'h0);
    @(posedge clk);
    #1;
    chk("rstmid_t2_dm_rvalid", bus.o_dm_rvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h10, 1'b1, 32'h10, 2'b00, 32'h0);
    chk("postrst_dm_gnt", bus.o_dm_gnt, 1'b1);
    chk("postrst_if_gnt", bus.o_if_gnt, 1'b0);
    push(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    tick();

    // address wrap modulo 2^16 bytes
    drive(1'b0, 32'h0, 1'b1, 32'h00010000, 2'b11, 32'h5A5A5A5A);
    chk_mem("wrap_wr", 1'b0, 1'b1, 14'h0, 4'b1111, 32'h5A5A5A5A);
    push(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h00000000, 2'b00, 32'h0);
    push(1'b0, 1'b1, 32'h5A5A5A5A, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0);
    chk_mem("idle", 1'b0, 1'b0, 14'h0, 4'b0000, 32'h0);
    push(1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
